axi4_lite_gpio_slave: RTL and testbench

AXI4-Lite responder exposing a GPIO register bank, sized for the 9-bit address / 32-bit data interface our axi_traffic_gen initiators drive. It sits at the slave end of an AXI4-Lite link. It accepts write and read transactions, drives the gpio outputs and tristate enables, and samples the gpio inputs through a synchronizer. Register map: 0x000 GPIO_DATA, 0x004 GPIO_TRI.

---
 rtl/axi4_lite_gpio_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_lite_gpio_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_gpio_slave.sv
// AXI4-Lite GPIO responder: DATA at 0x000 and TRI at 0x004, with gpio_io_i brought in through a 2-flop synchronizer.
// Defining GPIO_IRQ_EN adds ISR at 0x120, IER at 0x128 and the ip2intc_irpt output.
module axi4_lite_gpio_slave #(
   parameter int unsigned GPIO_WIDTH   = 32,
   parameter logic [31:0] DOUT_DEFAULT = 32'h0,
   parameter logic [31:0] TRI_DEFAULT  = 32'hFFFF_FFFF
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic [8:0]            s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [8:0]            s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   input  logic [GPIO_WIDTH-1:0] gpio_io_i,
   output logic [GPIO_WIDTH-1:0] gpio_io_o,
   output logic [GPIO_WIDTH-1:0] gpio_io_t
`ifdef GPIO_IRQ_EN
   ,
   output logic                  ip2intc_irpt
`endif
);

   localparam logic [6:0] A_DATA = 7'h00;
   localparam logic [6:0] A_TRI  = 7'h01;
   localparam logic [6:0] A_ISR  = 7'h48;
   localparam logic [6:0] A_IER  = 7'h4A;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_RESP} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic                  aw_full, w_full;
   logic [6:0]            aw_idx;
   logic [31:0]           w_data;
   logic [3:0]            w_strb;
   logic [GPIO_WIDTH-1:0] dout, tri_reg, sync_meta, sync_in;
   logic [31:0]           dout_ext, tri_ext, din_ext, dout_merged, tri_merged, rd_data;
   logic [1:0]            rd_resp;
   logic                  wr_mapped, aw_hs, w_hs, ar_hs, commit;
   logic                  unused_addr_lsbs;

   assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign s_axi_awready = !aw_full && (w_state != W_RESP);
   assign s_axi_wready  = !w_full  && (w_state != W_RESP);
   assign s_axi_bvalid  = (w_state == W_RESP);
   assign s_axi_arready = (r_state == R_IDLE);
   assign s_axi_rvalid  = (r_state == R_RESP);
   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign commit = (w_state == W_COMMIT);
   assign gpio_io_o = dout;
   assign gpio_io_t = tri_reg;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      merge = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) merge[8*b +: 8] = data[8*b +: 8];
   endfunction

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      dout_ext = '0;
      tri_ext  = '0;
      din_ext  = '0;
      dout_ext[GPIO_WIDTH-1:0] = dout;
      tri_ext[GPIO_WIDTH-1:0]  = tri_reg;
      din_ext[GPIO_WIDTH-1:0]  = (sync_in & tri_reg) | (dout & ~tri_reg);
      dout_merged = merge(dout_ext, w_data, w_strb);
      tri_merged  = merge(tri_ext, w_data, w_strb);
   end

   always_comb begin
      wr_mapped = 1'b0;
      case (aw_idx)
         A_DATA, A_TRI: wr_mapped = 1'b1;
`ifdef GPIO_IRQ_EN
         A_ISR, A_IER:  wr_mapped = 1'b1;
`endif
         default:       wr_mapped = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = w_state;
      unique case (w_state)
         W_IDLE:   if ((aw_full || aw_hs) && (w_full || w_hs)) w_state_nxt = W_COMMIT;
         W_COMMIT: w_state_nxt = W_RESP;
         W_RESP:   if (s_axi_bready) w_state_nxt = W_IDLE;
         default:  w_state_nxt = W_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state     <= W_IDLE;
         aw_full     <= 1'b0;
         w_full      <= 1'b0;
         aw_idx      <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         s_axi_bresp <= RESP_OKAY;
      end else begin
         w_state <= w_state_nxt;
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= s_axi_awaddr[8:2];
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
         end
         if (commit) s_axi_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         if ((w_state == W_RESP) && s_axi_bready) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         dout    <= DOUT_DEFAULT[GPIO_WIDTH-1:0];
         tri_reg <= TRI_DEFAULT[GPIO_WIDTH-1:0];
      end else if (commit) begin
         if (aw_idx == A_DATA) dout    <= dout_merged[GPIO_WIDTH-1:0];
         if (aw_idx == A_TRI)  tri_reg <= tri_merged[GPIO_WIDTH-1:0];
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         sync_meta <= '0;
         sync_in   <= '0;
      end else begin
         sync_meta <= gpio_io_i;
         sync_in   <= sync_meta;
      end
   end

`ifdef GPIO_IRQ_EN
   logic                  isr, ier, isr_w1c;
   logic [GPIO_WIDTH-1:0] sync_prev;

   assign isr_w1c = commit && (aw_idx == A_ISR) && w_strb[0] && w_data[0];

   // A new input change wins over a simultaneous write-1-to-clear.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         isr          <= 1'b0;
         ier          <= 1'b0;
         sync_prev    <= '0;
         ip2intc_irpt <= 1'b0;
      end else begin
         sync_prev    <= sync_in;
         isr          <= (sync_in != sync_prev) || (isr && !isr_w1c);
         if (commit && (aw_idx == A_IER) && w_strb[0]) ier <= w_data[0];
         ip2intc_irpt <= isr && ier;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (s_axi_araddr[8:2])
         A_DATA:  rd_data = din_ext;
         A_TRI:   rd_data = tri_ext;
`ifdef GPIO_IRQ_EN
         A_ISR:   rd_data = {31'b0, isr};
         A_IER:   rd_data = {31'b0, ier};
`endif
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      unique case (r_state)
         R_IDLE:  if (s_axi_arvalid) r_state_nxt = R_RESP;
         R_RESP:  if (s_axi_rready) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state     <= R_IDLE;
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else begin
         r_state <= r_state_nxt;
         if (ar_hs) begin
            s_axi_rdata <= rd_data;
            s_axi_rresp <= rd_resp;
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_gpio_slave.sv
// Randomized bench for axi4_lite_gpio_slave (default build) against a register-level model of the GPIO bank.
module tb_axi4_lite_gpio_slave;

   localparam logic [31:0] DOUT_DEF = 32'h0;
   localparam logic [31:0] TRI_DEF  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, gpio_io_i, gpio_io_o, gpio_io_t;

   always #5 clk = ~clk;

   axi4_lite_gpio_slave dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .gpio_io_i(gpio_io_i), .gpio_io_o(gpio_io_o), .gpio_io_t(gpio_io_t)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: register contents plus the gpio_io_i value seen at each edge, newest first.
   logic [31:0] dout_m = DOUT_DEF;
   logic [31:0] tri_m  = TRI_DEF;
   logic [31:0] in_hist[$] = '{32'h0, 32'h0, 32'h0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: handshake not seen within cycle budget at %0t", name, $time);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_hist = '{32'h0, 32'h0, 32'h0};
      else begin
         in_hist.push_front(gpio_io_i);
         void'(in_hist.pop_back());
      end
   end

   always @(negedge clk) begin
      check("gpio_io_o", gpio_io_o, dout_m);
      check("gpio_io_t", gpio_io_t, tri_m);
   end

   function automatic bit is_mapped(input logic [8:0] addr);
      return (addr >> 2) < 2;
   endfunction

   // Expected read result at the edge that just passed: synchronized input is the value seen two edges earlier.
   function automatic void exp_read(input logic [8:0] addr, output logic [31:0] d, output logic [1:0] r);
      r = 2'b00;
      case (int'(addr >> 2))
         0:       d = (in_hist[2] & tri_m) | (dout_m & ~tri_m);
         1:       d = tri_m;
         default: begin d = 32'h0; r = 2'b10; end
      endcase
   endfunction

   task automatic model_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] mask = 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
      if ((addr >> 2) == 0) dout_m = (dout_m & ~mask) | (data & mask);
      else if ((addr >> 2) == 1) tri_m = (tri_m & ~mask) | (data & mask);
   endtask

   task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit offer_aw);
      bit aw_done = 0, w_done = 0;
      logic aw_rdy, w_rdy;
      int cyc = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         awaddr = addr; wdata = data; wstrb = strb;
         aw_rdy = awready; w_rdy = wready;
         @(posedge clk); #1;
         if (awvalid && aw_rdy) aw_done = 1;
         if (wvalid && w_rdy) w_done = 1;
         cyc++;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) begin timeout_fail("write_handshake"); return; end
      check("bvalid_before_commit", bvalid, 0);
      @(posedge clk); #1;
      model_write(addr, data, strb);
      check("bvalid_after_commit", bvalid, 1);
      check("bresp", bresp, is_mapped(addr) ? 32'd0 : 32'd2);
      for (int i = 0; i < b_dly; i++) begin
         if (offer_aw) begin awaddr = 9'h004; awvalid = 1; end
         check("bvalid_hold", bvalid, 1);
         check("awready_in_resp", awready, 0);
         check("wready_in_resp", wready, 0);
         @(posedge clk); #1;
      end
      awvalid = 0;
      check("bvalid_hold_end", bvalid, 1);
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      check("bvalid_after_bready", bvalid, 0);
      check("awready_after_bready", awready, 1);
      check("wready_after_bready", wready, 1);
   endtask

   task automatic axi_read(input logic [8:0] addr, input int r_dly, output logic [31:0] got);
      logic [31:0] ed;
      logic [1:0] er;
      logic ar_rdy;
      bit done = 0;
      int cyc = 0;
      got = 32'hX;
      check("rvalid_idle", rvalid, 0);
      araddr = addr; arvalid = 1;
      while (!done && cyc < 40) begin
         ar_rdy = arready;
         @(posedge clk); #1;
         if (ar_rdy) done = 1;
         cyc++;
      end
      arvalid = 0;
      if (!done) begin timeout_fail("read_handshake"); return; end
      exp_read(addr, ed, er);
      got = rdata;
      check("rvalid", rvalid, 1);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      for (int i = 0; i < r_dly; i++) begin
         @(posedge clk); #1;
         check("rvalid_hold", rvalid, 1);
         check("rdata_stable", rdata, ed);
         check("arready_in_resp", arready, 0);
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      check("rvalid_after_rready", rvalid, 0);
      check("arready_after_rready", arready, 1);
   endtask

   initial begin
      logic [31:0] got;
      logic [8:0] a;
      gpio_io_i = 32'h5;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_arready", arready, 1);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rdata", rdata, 0);
      check("rst_gpio_o", gpio_io_o, 32'h0);
      check("rst_gpio_t", gpio_io_t, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      #1;

      axi_read(9'h000, 0, got);
      check("first_read_literal", got, 32'h5);

      axi_write(9'h004, 32'h0, 4'hF, 0, 3, 0, 0);
      axi_write(9'h000, 32'hA5A5_A5A5, 4'hF, 3, 0, 0, 0);
      check("tri_literal", gpio_io_t, 32'h0);
      check("dout_literal", gpio_io_o, 32'hA5A5_A5A5);

      axi_write(9'h000, 32'h0, 4'hF, 0, 0, 0, 0);
      axi_write(9'h000, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, 0);
      check("strobe_literal", gpio_io_o, 32'h0000_FF00);
      axi_read(9'h000, 1, got);
      check("strobe_readback_literal", got, 32'h0000_FF00);

      axi_write(9'h004, 32'h0, 4'hF, 0, 0, 5, 1);

      axi_read(9'h010, 2, got);
      check("unmapped_read_literal", got, 32'h0);
      axi_write(9'h1FC, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
      check("unmapped_write_dout", gpio_io_o, 32'h0000_FF00);
      check("unmapped_write_tri", gpio_io_t, 32'h0);

      // Asynchronous reset between the AW and W handshakes.
      awaddr = 9'h000; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0;
      #2 rst_n = 0;
      dout_m = DOUT_DEF; tri_m = TRI_DEF;
      #1;
      check("arst_gpio_o", gpio_io_o, DOUT_DEF);
      check("arst_gpio_t", gpio_io_t, TRI_DEF);
      check("arst_awready", awready, 1);
      check("arst_wready", wready, 1);
      check("arst_bvalid", bvalid, 0);
      @(posedge clk); #3 rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("no_bvalid_after_reset", bvalid, 0);
      end

      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(0, 4))
            0: begin
               gpio_io_i = $urandom;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            1, 2: begin
               a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(8, 511))
                                               : 9'($urandom_range(0, 7));
               axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            default: begin
               a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(8, 511))
                                               : 9'($urandom_range(0, 7));
               axi_read(a, $urandom_range(0, 3), got);
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
